// File: rtl/cpu_trace_buffer.sv
// Per-cycle trace capture for the single-cycle CPU: circular pre-trigger history,
// stop on PC-match trigger or halt (PC stuck), then oldest-first readout over valid/ready.
module cpu_trace_buffer #(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned INST_W      = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned POST_CNT    = 4,
    parameter int unsigned HALT_CYCLES = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         arm,
    input  logic                         sample_en,
    input  logic [DATA_W-1:0]            pc,
    input  logic [INST_W-1:0]            instruction,
    input  logic [DATA_W-1:0]            alu_out,
    input  logic                         trig_en,
    input  logic [DATA_W-1:0]            trig_pc,
    output logic                         busy,
    output logic                         done,
    output logic                         triggered,
    output logic                         halted,
    output logic [$clog2(DEPTH):0]       fill,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [2*DATA_W+INST_W-1:0]   rd_data
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned FILL_W  = PTR_W + 1;
    localparam int unsigned ENTRY_W = 2*DATA_W + INST_W;
    localparam int unsigned HALT_W  = $clog2(HALT_CYCLES + 1);
    localparam int unsigned POST_W  = PTR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                state, state_next;
    logic [ENTRY_W-1:0]    mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr, oldest_ptr;
    logic [POST_W-1:0]     post_cnt;
    logic [HALT_W-1:0]     halt_cnt;
    logic [DATA_W-1:0]     prev_pc;
    logic                  have_prev;
    logic                  sample, same_pc, trig_hit, halt_hit, post_last, xfer;

    // Oldest stored entry: fill saturates at DEPTH, whose low bits are zero, giving wr_ptr.
    assign oldest_ptr = wr_ptr - PTR_W'(fill);

    // Next-state decode plus per-sample trigger / halt / post-count events.
    always_comb begin
        state_next = state;
        sample     = 1'b0;
        trig_hit   = 1'b0;
        halt_hit   = 1'b0;
        post_last  = 1'b0;
        same_pc    = have_prev && (pc == prev_pc);
        xfer       = (state == S_DRAIN) && rd_valid && rd_ready;
        if ((state == S_ARMED || state == S_POST) && sample_en) begin
            sample    = 1'b1;
            halt_hit  = same_pc && (halt_cnt == HALT_W'(HALT_CYCLES - 1));
            trig_hit  = (state == S_ARMED) && trig_en && (pc == trig_pc);
            post_last = (state == S_POST) && (post_cnt == POST_W'(1));
        end
        case (state)
            S_IDLE:  if (arm) state_next = S_ARMED;
            S_ARMED: begin
                if (halt_hit || (trig_hit && POST_CNT == 0)) state_next = S_DRAIN;
                else if (trig_hit)                          state_next = S_POST;
            end
            S_POST:  if (halt_hit || post_last) state_next = S_DRAIN;
            S_DRAIN: if (xfer && fill == FILL_W'(1)) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Capture storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (!reset && sample) mem[wr_ptr] <= {pc, instruction, alu_out};
    end

    // Pointers, counters, sticky flags and the registered read port.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            triggered <= 1'b0;
            halted    <= 1'b0;
            fill      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            post_cnt  <= '0;
            halt_cnt  <= '0;
            prev_pc   <= '0;
            have_prev <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            busy <= (state_next == S_ARMED) || (state_next == S_POST);
            done <= (state_next == S_DRAIN);

            if (state == S_IDLE && arm) begin
                triggered <= 1'b0;
                halted    <= 1'b0;
                fill      <= '0;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                post_cnt  <= '0;
                halt_cnt  <= '0;
                have_prev <= 1'b0;
            end

            if (sample) begin
                wr_ptr    <= wr_ptr + PTR_W'(1);
                prev_pc   <= pc;
                have_prev <= 1'b1;
                halt_cnt  <= same_pc ? halt_cnt + HALT_W'(1) : '0;
                if (fill != FILL_W'(DEPTH)) fill <= fill + FILL_W'(1);
                if (state == S_POST) post_cnt <= post_cnt - POST_W'(1);
                if (trig_hit) begin
                    triggered <= 1'b1;
                    post_cnt  <= POST_W'(POST_CNT);
                end
                if (halt_hit) halted <= 1'b1;
            end

            if (state == S_DRAIN) begin
                if (!rd_valid) begin
                    // First DRAIN cycle: present the oldest entry.
                    rd_data  <= mem[oldest_ptr];
                    rd_ptr   <= oldest_ptr + PTR_W'(1);
                    rd_valid <= 1'b1;
                end else if (rd_ready) begin
                    fill <= fill - FILL_W'(1);
                    if (fill == FILL_W'(1)) begin
                        rd_valid <= 1'b0;
                    end else begin
                        rd_data <= mem[rd_ptr];
                        rd_ptr  <= rd_ptr + PTR_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer with DEPTH=8, POST_CNT=3, HALT_CYCLES=4.
module tb_cpu_trace_buffer;

    logic          clock = 1'b0;
    logic          reset, arm, sample_en, trig_en, rd_ready;
    logic [63:0]   pc, alu_out, trig_pc;
    logic [31:0]   instruction;
    logic          busy, done, triggered, halted, rd_valid;
    logic [3:0]    fill;
    logic [159:0]  rd_data;

    int            checks   = 0;
    int            failures = 0;
    logic [63:0]   exp_q [$];

    cpu_trace_buffer #(
        .DATA_W(64), .INST_W(32), .DEPTH(8), .POST_CNT(3), .HALT_CYCLES(4)
    ) dut (
        .clock(clock), .reset(reset), .arm(arm), .sample_en(sample_en),
        .pc(pc), .instruction(instruction), .alu_out(alu_out),
        .trig_en(trig_en), .trig_pc(trig_pc),
        .busy(busy), .done(done), .triggered(triggered), .halted(halted),
        .fill(fill), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data)
    );

    always #5 clock = ~clock;

    // Entry the bench expects for a given pc.
    function automatic logic [159:0] ent(input logic [63:0] p);
        logic [31:0] lo;
        lo = p[31:0];
        return {p, lo ^ 32'hA5A5_5A5A, p + 64'h1000};
    endfunction

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then read 1 time unit after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [63:0] p);
        {pc, instruction, alu_out} = ent(p);
        sample_en = 1'b1;
        step();
        sample_en = 1'b0;
    endtask

    task automatic stall(input logic [63:0] p);
        {pc, instruction, alu_out} = ent(p);
        sample_en = 1'b0;
        step();
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    // Read out exp_q, optionally with random backpressure, then confirm return to IDLE.
    task automatic drain(input bit rnd);
        int           idx;
        int           n;
        bit           stalled;
        logic [159:0] held;
        n = exp_q.size();
        idx = 0;
        stalled = 1'b0;
        held = '0;
        rd_ready = 1'b0;
        for (int c = 0; c < 400 && idx < n; c++) begin
            step();
            if (stalled) check("hold", 192'({rd_valid, rd_data}), 192'({1'b1, held}));
            stalled = 1'b0;
            if (rd_valid) begin
                rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (rd_ready) begin
                    check("rd_data", 192'(rd_data), 192'(ent(exp_q[idx])));
                    idx++;
                end else begin
                    held = rd_data;
                    stalled = 1'b1;
                end
            end else begin
                rd_ready = 1'b0;
            end
        end
        check("drain_cnt", 192'(idx), 192'(n));
        step();
        rd_ready = 1'b0;
        check("drain_end", 192'({rd_valid, done, busy, fill}), 192'(0));
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; sample_en = 1'b0; trig_en = 1'b0; rd_ready = 1'b0;
        pc = '0; instruction = '0; alu_out = '0; trig_pc = '0;
        step();
        step();
        reset = 1'b0;
        check("reset_out", 192'({busy, done, triggered, halted, fill, rd_valid, rd_data}), 192'(0));

        // Wrap: trigger at 40, 14 samples total.
        trig_en = 1'b1; trig_pc = 64'd40;
        do_arm();
        check("armed_busy", 192'({busy, done, fill}), 192'({1'b1, 1'b0, 4'd0}));
        for (int i = 0; i <= 10; i++) push(64'(i * 4));
        check("trig_post", 192'({busy, triggered, done}), 192'(3'b110));
        for (int i = 11; i <= 13; i++) push(64'(i * 4));
        check("wrap_done", 192'({busy, done, triggered, halted, fill, rd_valid}),
              192'({1'b0, 1'b1, 1'b1, 1'b0, 4'd8, 1'b0}));
        step();
        check("first_valid", 192'({rd_valid, rd_data}), 192'({1'b1, ent(64'd24)}));
        exp_q.delete();
        for (int i = 6; i <= 13; i++) exp_q.push_back(64'(i * 4));
        drain(1'b0);

        // Early trigger: no wrap, fill=6.
        trig_pc = 64'd8;
        do_arm();
        for (int i = 0; i <= 5; i++) push(64'(i * 4));
        check("early_done", 192'({done, triggered, halted, fill}), 192'({3'b110, 4'd6}));
        exp_q.delete();
        for (int i = 0; i <= 5; i++) exp_q.push_back(64'(i * 4));
        drain(1'b0);

        // Halt: 0, 4, then 0x100 five times.
        trig_en = 1'b0;
        do_arm();
        check("arm_clears", 192'({triggered, halted, fill}), 192'(0));
        push(64'd0);
        push(64'd4);
        for (int i = 0; i < 4; i++) push(64'h100);
        check("pre_halt", 192'({busy, halted}), 192'(2'b10));
        push(64'h100);
        check("halt_done", 192'({done, triggered, halted, fill}), 192'({3'b101, 4'd7}));
        exp_q.delete();
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd4);
        for (int i = 0; i < 5; i++) exp_q.push_back(64'h100);
        drain(1'b0);

        // Stalls with trigger pc on the bus, re-arm ignored, random backpressure.
        trig_en = 1'b1; trig_pc = 64'd20;
        do_arm();
        for (int i = 0; i <= 8; i++) begin
            stall(64'd20);
            push(64'(i * 4));
            if (i == 2) begin
                do_arm();
                check("rearm_ignored", 192'({busy, fill}), 192'({1'b1, 4'd3}));
            end
        end
        check("stall_done", 192'({done, triggered, halted, fill}), 192'({3'b110, 4'd8}));
        exp_q.delete();
        for (int i = 1; i <= 8; i++) exp_q.push_back(64'(i * 4));
        drain(1'b1);

        // Reset during POST.
        trig_pc = 64'd8;
        do_arm();
        for (int i = 0; i <= 3; i++) push(64'(i * 4));
        check("in_post", 192'({busy, triggered, done}), 192'(3'b110));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset_post", 192'({busy, done, triggered, halted, fill, rd_valid, rd_data}), 192'(0));

        // Reset mid-DRAIN.
        do_arm();
        for (int i = 0; i <= 5; i++) push(64'(i * 4));
        rd_ready = 1'b1;
        step();
        check("drain_first", 192'({rd_valid, rd_data}), 192'({1'b1, ent(64'd0)}));
        step();
        check("drain_second", 192'({rd_valid, fill, rd_data}), 192'({1'b1, 4'd5, ent(64'd4)}));
        rd_ready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset_drain", 192'({busy, done, triggered, halted, fill, rd_valid, rd_data}), 192'(0));
        step();
        check("idle_after", 192'({busy, done, rd_valid}), 192'(0));
        do_arm();
        check("rearm_after", 192'({busy, done, fill}), 192'({2'b10, 4'd0}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
